// File: rtl/preg_pkg.sv
// preg_pkg -- shared widths and FSM encoding for the pointer-register write scheduler.
//   PREG_IDX_W  : pointer register index width
//   PREG_LBID_W : label id width
//   PREG_OFS_W  : offset width (add arithmetic wraps at this width)
//   state_e     : scheduler FSM state encoding
package preg_pkg;
    localparam int PREG_IDX_W  = 6;
    localparam int PREG_LBID_W = 12;
    localparam int PREG_OFS_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request vector
//   take       : grant is consumed this cycle; updates the last-grant register
//   gnt[1:0]   : one-hot grant (combinational), zero when no request
// After reset the last grant points at requester 1, so requester 0 wins first.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);
    logic last_q, last_d;

    always_comb begin
        if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
        else              gnt = req;
        last_d = last_q;
        if (take && (|req)) last_d = gnt[1];
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
endmodule

// File: rtl/preg_write_sched.sv
// preg_write_sched -- arbitrates two requesters onto the pointer register file write port.
//   clk, reset           : clock, synchronous active-high reset
//   req0/1, ack0/1       : request (held until ack), one-cycle ack in the write cycle
//   pw*/lbidw*/ofsw*     : requester index, label id, offset (or delta for add ops)
//   add0/1               : 1 = offset-add op, 0 = load op
//   we, pw, lbidw, ofsw  : register file write port
//   pr, lbidr, ofsr      : register file read port (read data is combinational)
//   busy                 : FSM not idle
// Build option: define PREG_SCHED_OFSADD_EN to enable offset-add ops
// (IDLE->READ->WRITE). Without it add0/add1 are ignored and pr is tied to 0.
module preg_write_sched
    import preg_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic                   req1,
    output logic                   ack0,
    output logic                   ack1,
    input  logic [PREG_IDX_W-1:0]  pw0,
    input  logic [PREG_IDX_W-1:0]  pw1,
    input  logic [PREG_LBID_W-1:0] lbidw0,
    input  logic [PREG_LBID_W-1:0] lbidw1,
    input  logic [PREG_OFS_W-1:0]  ofsw0,
    input  logic [PREG_OFS_W-1:0]  ofsw1,
    input  logic                   add0,
    input  logic                   add1,
    output logic                   we,
    output logic [PREG_IDX_W-1:0]  pw,
    output logic [PREG_LBID_W-1:0] lbidw,
    output logic [PREG_OFS_W-1:0]  ofsw,
    output logic [PREG_IDX_W-1:0]  pr,
    input  logic [PREG_LBID_W-1:0] lbidr,
    input  logic [PREG_OFS_W-1:0]  ofsr,
    output logic                   busy
);
    state_e                 state_q, state_d;
    logic                   we_q, we_d, ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic [PREG_IDX_W-1:0]  pw_q, pw_d;
    logic [PREG_LBID_W-1:0] lbidw_q, lbidw_d;
    logic [PREG_OFS_W-1:0]  ofsw_q, ofsw_d;
    logic [1:0]             gnt;

    // Arbiter only advances when the grant is actually taken in IDLE.
    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1, req0}),
        .take  (state_q == ST_IDLE),
        .gnt   (gnt)
    );

    logic [PREG_IDX_W-1:0]  pw_sel;
    logic [PREG_LBID_W-1:0] lbid_sel;
    logic [PREG_OFS_W-1:0]  ofs_sel;
    assign pw_sel   = gnt[1] ? pw1    : pw0;
    assign lbid_sel = gnt[1] ? lbidw1 : lbidw0;
    assign ofs_sel  = gnt[1] ? ofsw1  : ofsw0;

`ifdef PREG_SCHED_OFSADD_EN
    // Operation latched at grant so later req/input changes cannot alter it.
    logic                  add_sel;
    logic [PREG_IDX_W-1:0] pr_q, pr_d, lat_pw_q, lat_pw_d;
    logic [PREG_OFS_W-1:0] lat_ofs_q, lat_ofs_d;
    logic                  lat_g1_q, lat_g1_d;
    assign add_sel = gnt[1] ? add1 : add0;
    assign pr      = pr_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{add0, add1, lbidr, ofsr};
    assign pr            = '0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = busy_q;
        pw_d    = pw_q;
        lbidw_d = lbidw_q;
        ofsw_d  = ofsw_q;
`ifdef PREG_SCHED_OFSADD_EN
        pr_d      = pr_q;
        lat_pw_d  = lat_pw_q;
        lat_ofs_d = lat_ofs_q;
        lat_g1_d  = lat_g1_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    busy_d  = 1'b1;
                    state_d = ST_WRITE;
                    we_d    = 1'b1;
                    ack0_d  = gnt[0];
                    ack1_d  = gnt[1];
                    pw_d    = pw_sel;
                    lbidw_d = lbid_sel;
                    ofsw_d  = ofs_sel;
`ifdef PREG_SCHED_OFSADD_EN
                    // Add op: cancel the direct write and go read the target first.
                    if (add_sel) begin
                        state_d   = ST_READ;
                        we_d      = 1'b0;
                        ack0_d    = 1'b0;
                        ack1_d    = 1'b0;
                        pw_d      = pw_q;
                        lbidw_d   = lbidw_q;
                        ofsw_d    = ofsw_q;
                        pr_d      = pw_sel;
                        lat_pw_d  = pw_sel;
                        lat_ofs_d = ofs_sel;
                        lat_g1_d  = gnt[1];
                    end
`endif
                end
            end
`ifdef PREG_SCHED_OFSADD_EN
            ST_READ: begin
                // Read data is captured straight into the write-port registers.
                state_d = ST_WRITE;
                we_d    = 1'b1;
                ack0_d  = ~lat_g1_q;
                ack1_d  = lat_g1_q;
                pw_d    = lat_pw_q;
                lbidw_d = lbidr;
                ofsw_d  = ofsr + lat_ofs_q;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
            pw_q      <= '0;
            lbidw_q   <= '0;
            ofsw_q    <= '0;
`ifdef PREG_SCHED_OFSADD_EN
            pr_q      <= '0;
            lat_pw_q  <= '0;
            lat_ofs_q <= '0;
            lat_g1_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
            pw_q      <= pw_d;
            lbidw_q   <= lbidw_d;
            ofsw_q    <= ofsw_d;
`ifdef PREG_SCHED_OFSADD_EN
            pr_q      <= pr_d;
            lat_pw_q  <= lat_pw_d;
            lat_ofs_q <= lat_ofs_d;
            lat_g1_q  <= lat_g1_d;
`endif
        end
    end

    assign we    = we_q;
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign busy  = busy_q;
    assign pw    = pw_q;
    assign lbidw = lbidw_q;
    assign ofsw  = ofsw_q;
endmodule

// File: tb/tb_preg_write_sched.sv
// tb_preg_write_sched -- directed bench for preg_write_sched.
// Expectations for add ops follow the PREG_SCHED_OFSADD_EN build option.
// obs packs {busy, we, ack1, ack0, pw, lbidw, ofsw}.
module tb_preg_write_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 0, req1 = 0, add0 = 0, add1 = 0;
    logic [5:0]  pw0 = 0, pw1 = 0;
    logic [11:0] lbidw0 = 0, lbidw1 = 0;
    logic [15:0] ofsw0 = 0, ofsw1 = 0;
    logic        ack0, ack1, we, busy;
    logic [5:0]  pw, pr;
    logic [11:0] lbidw, lbidr;
    logic [15:0] ofsw, ofsr;
    logic [11:0] rf_lbid [64];
    logic [15:0] rf_ofs  [64];
    logic [37:0] obs;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    assign lbidr = rf_lbid[pr];
    assign ofsr  = rf_ofs[pr];
    assign obs   = {busy, we, ack1, ack0, pw, lbidw, ofsw};

    preg_write_sched dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1),
        .pw0(pw0), .pw1(pw1), .lbidw0(lbidw0), .lbidw1(lbidw1),
        .ofsw0(ofsw0), .ofsw1(ofsw1), .add0(add0), .add1(add1),
        .we(we), .pw(pw), .lbidw(lbidw), .ofsw(ofsw),
        .pr(pr), .lbidr(lbidr), .ofsr(ofsr), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; add0 = 0; add1 = 0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vecs++;
        if (obs !== 38'h0) begin errs++; $display("FAIL reset_obs: got %h want %h", obs, 38'h0); end
        vecs++;
        if (pr !== 6'd0) begin errs++; $display("FAIL reset_pr: got %h want %h", pr, 6'd0); end
        reset = 1'b0;
    endtask

    task automatic test_load();
        logic [37:0] e;
        do_reset();
        req0 = 1; pw0 = 6'd5; lbidw0 = 12'h123; ofsw0 = 16'h0040; add0 = 0;
        vecs++;
        if (obs !== 38'h0) begin errs++; $display("FAIL load_pre: got %h want %h", obs, 38'h0); end
        tick();
        e = {4'b1101, 6'd5, 12'h123, 16'h0040};
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL load_write: got %h want %h", obs, e); end
        req0 = 0;
        tick();
        e = {4'b0000, 6'd5, 12'h123, 16'h0040};
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL load_idle: got %h want %h", obs, e); end
        tick();
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL load_stay_idle: got %h want %h", obs, e); end
    endtask

    task automatic test_back_to_back();
        logic [37:0] e;
        do_reset();
        req0 = 1; pw0 = 6'd1; lbidw0 = 12'h111; ofsw0 = 16'h1000; add0 = 0;
        req1 = 1; pw1 = 6'd2; lbidw1 = 12'h222; ofsw1 = 16'h2000; add1 = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k % 2 == 0) e = {4'b1101, 6'd1, 12'h111, 16'h1000};
            else            e = {4'b1110, 6'd2, 12'h222, 16'h2000};
            vecs++;
            if (obs !== e) begin errs++; $display("FAIL rr_write%0d: got %h want %h", k, obs, e); end
            tick();
            e[37:34] = 4'b0000;
            vecs++;
            if (obs !== e) begin errs++; $display("FAIL rr_idle%0d: got %h want %h", k, obs, e); end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_add();
        logic [37:0] e;
        do_reset();
        rf_lbid[3] = 12'h0AA; rf_ofs[3] = 16'hFFF0;
        req1 = 1; pw1 = 6'd3; lbidw1 = 12'h555; ofsw1 = 16'h0020; add1 = 1;
        tick();
`ifdef PREG_SCHED_OFSADD_EN
        e = 38'h0 | {4'b1000, 34'h0};
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL add_read: got %h want %h", obs, e); end
        vecs++;
        if (pr !== 6'd3) begin errs++; $display("FAIL add_pr: got %h want %h", pr, 6'd3); end
        tick();
        e = {4'b1110, 6'd3, 12'h0AA, 16'h0010};
`else
        e = {4'b1110, 6'd3, 12'h555, 16'h0020};
`endif
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL add_write: got %h want %h", obs, e); end
        req1 = 0; add1 = 0;
        tick();
        e[37:34] = 4'b0000;
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL add_idle: got %h want %h", obs, e); end
        // Wrap at 16 bits, and req/input changes after grant are ignored.
        do_reset();
        rf_lbid[9] = 12'h3FF; rf_ofs[9] = 16'hFFFF;
        req0 = 1; pw0 = 6'd9; lbidw0 = 12'h001; ofsw0 = 16'h0001; add0 = 1;
        tick();
`ifdef PREG_SCHED_OFSADD_EN
        vecs++;
        if (obs !== {4'b1000, 34'h0}) begin errs++; $display("FAIL wrap_read: got %h want %h", obs, {4'b1000, 34'h0}); end
        req0 = 0; pw0 = 6'h3F; ofsw0 = 16'h7777;
        tick();
        e = {4'b1101, 6'd9, 12'h3FF, 16'h0000};
`else
        e = {4'b1101, 6'd9, 12'h001, 16'h0001};
`endif
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL wrap_write: got %h want %h", obs, e); end
        req0 = 0; add0 = 0;
        tick();
        e[37:34] = 4'b0000;
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL wrap_idle: got %h want %h", obs, e); end
    endtask

    task automatic test_reset_abort();
        logic [37:0] e;
        do_reset();
        req1 = 1; pw1 = 6'd3; lbidw1 = 12'h456; ofsw1 = 16'h0020; add1 = 1;
`ifdef PREG_SCHED_OFSADD_EN
        tick();
        vecs++;
        if (obs !== {4'b1000, 34'h0}) begin errs++; $display("FAIL abort_read: got %h want %h", obs, {4'b1000, 34'h0}); end
`endif
        reset = 1; add1 = 0;
        req0 = 1; pw0 = 6'd7; lbidw0 = 12'h777; ofsw0 = 16'h0707; add0 = 0;
        tick();
        vecs++;
        if (obs !== 38'h0) begin errs++; $display("FAIL abort_reset: got %h want %h", obs, 38'h0); end
        vecs++;
        if (pr !== 6'd0) begin errs++; $display("FAIL abort_pr: got %h want %h", pr, 6'd0); end
        reset = 0;
        tick();
        e = {4'b1101, 6'd7, 12'h777, 16'h0707};
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL abort_first: got %h want %h", obs, e); end
        req0 = 0;
        tick();
        e[37:34] = 4'b0000;
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL abort_idle: got %h want %h", obs, e); end
        tick();
        e = {4'b1110, 6'd3, 12'h456, 16'h0020};
        vecs++;
        if (obs !== e) begin errs++; $display("FAIL abort_second: got %h want %h", obs, e); end
        req1 = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rf_lbid[i] = 12'h0;
            rf_ofs[i]  = 16'h0;
        end
        test_reset();
        test_load();
        test_back_to_back();
        test_add();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
